// File: rtl/mdu_seq_unit.sv
// Sequential multiply/divide unit with architectural HI/LO registers.
// Operations occupy a fixed number of busy cycles; results land in HI/LO at completion.
module mdu_seq_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;

  state_t           w_stateNext;
  logic [CNT_W-1:0] w_cntNext;
  logic [2:0]       w_opNext;
  logic [WIDTH-1:0] w_aNext;
  logic [WIDTH-1:0] w_bNext;
  logic [WIDTH-1:0] w_hiNext;
  logic [WIDTH-1:0] w_loNext;
  logic             w_doneNext;

  logic [2*WIDTH-1:0] w_sProd;
  logic [2*WIDTH-1:0] w_uProd;
  logic               w_aNeg;
  logic               w_bNeg;
  logic               w_isDiv;
  logic [WIDTH-1:0]   w_divA;
  logic [WIDTH-1:0]   w_divB;
  logic [WIDTH-1:0]   w_safeB;
  logic [WIDTH-1:0]   w_uQuot;
  logic [WIDTH-1:0]   w_uRem;
  logic [WIDTH-1:0]   w_resHi;
  logic [WIDTH-1:0]   w_resLo;
  logic               w_resWrite;

  assign w_sProd = $signed({{WIDTH{r_a[WIDTH-1]}}, r_a}) * $signed({{WIDTH{r_b[WIDTH-1]}}, r_b});
  assign w_uProd = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

  // Signed division runs on magnitudes; signs are restored afterwards so the
  // quotient truncates toward zero and most-negative / -1 wraps back to itself.
  assign w_isDiv = (r_op == OP_DIV);
  assign w_aNeg  = w_isDiv & r_a[WIDTH-1];
  assign w_bNeg  = w_isDiv & r_b[WIDTH-1];
  assign w_divA  = w_aNeg ? -r_a : r_a;
  assign w_divB  = w_bNeg ? -r_b : r_b;
  assign w_safeB = (w_divB == '0) ? WIDTH'(1) : w_divB;
  assign w_uQuot = w_divA / w_safeB;
  assign w_uRem  = w_divA % w_safeB;

  always_comb begin
    w_resHi    = r_hi;
    w_resLo    = r_lo;
    w_resWrite = 1'b0;
    case (r_op)
      OP_MULT: begin
        {w_resHi, w_resLo} = w_sProd;
        w_resWrite         = 1'b1;
      end
      OP_MULTU: begin
        {w_resHi, w_resLo} = w_uProd;
        w_resWrite         = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        if (r_b != '0) begin
          w_resLo    = (w_aNeg ^ w_bNeg) ? -w_uQuot : w_uQuot;
          w_resHi    = w_aNeg ? -w_uRem : w_uRem;
          w_resWrite = 1'b1;
        end
      end
      default: begin
        w_resWrite = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_opNext    = r_op;
    w_aNext     = r_a;
    w_bNext     = r_b;
    w_hiNext    = r_hi;
    w_loNext    = r_lo;
    w_doneNext  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!cancel) begin
          if (start && (op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU)) begin
            w_stateNext = RUN;
            w_cntNext   = (op == OP_MULT || op == OP_MULTU) ? MULT_LOAD : DIV_LOAD;
            w_opNext    = op;
            w_aNext     = a;
            w_bNext     = b;
          end
          if (op == OP_MTHI) w_hiNext = a;
          if (op == OP_MTLO) w_loNext = a;
        end
      end
      RUN: begin
        // Cancel is deliberately ignored here: a launched operation always retires.
        if (r_cnt == CNT_ONE) begin
          w_stateNext = IDLE;
          w_cntNext   = '0;
          w_doneNext  = 1'b1;
          if (w_resWrite) begin
            w_hiNext = w_resHi;
            w_loNext = w_resLo;
          end
        end else begin
          w_cntNext = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_op    <= w_opNext;
      r_a     <= w_aNext;
      r_b     <= w_bNext;
      r_hi    <= w_hiNext;
      r_lo    <= w_loNext;
      r_done  <= w_doneNext;
    end
  end

  assign busy = (r_state == RUN);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
